clock_divider_bank: RTL and testbench
=====================================

Name: clock_divider_bank

Overview:
- Parametrised, multi-channel successor to the single fixed-ratio clock divider.
- Each of N_CH channels produces a divided square-wave enable/clock (`clk_out`) and a one-cycle terminal-count pulse (`tick`).
- Each channel's divide ratio is runtime-programmable through a valid/ready load port. New ratios are shadowed and applied only at a period boundary, so no runt pulses occur.
- Sits between the system clock and the timekeeping logic: seconds/minutes counters, display multiplex, blink.

Parameters:
- N_CH, 4, number of independent divider channels (1..16).
- WIDTH, 32, width of each channel's half-period counter and divisor.
- DEFAULT_DIV, 50000000, reset half-period (in clk cycles) loaded into every channel; must fit in WIDTH bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  N_CH  per-channel run enable.
- sync  in  1  phase-align pulse, applies to all channels.
- load_valid  in  1  divisor load request.
- load_ready  out  1  load can be accepted this cycle.
- load_ch  in  $clog2(N_CH) (min 1)  target channel of the load.
- load_div  in  WIDTH  new half-period D.
- pending  out  N_CH  channel has a shadowed divisor not yet applied.
- clk_out  out  N_CH  divided output; period 2*D clk cycles, 50% duty.
- tick  out  N_CH  one-cycle pulse on each clk_out toggle.

Behaviour:
- All state changes on the rising edge of clk; everything is synchronous, including rst.
- Reset (rst=1), per channel:
  - div = DEFAULT_DIV, shadow = 0, pending = 0;
  - count = 0, clk_out = 0, tick = 0.
- Reset has priority over every other input. A reset mid-period discards the pending load and the counter phase.
- Effective divisor: D_eff = (div == 0) ? 1 : div. With D_eff = 1, clk_out toggles every cycle.
- Counting, per channel, when en=1 and sync=0:
  - if count == D_eff-1: count <= 0, clk_out <= ~clk_out, tick <= 1;
  - else: count <= count+1, tick <= 0.
  - First toggle after reset is registered D_eff cycles after rst deasserts.
- en=0: count and clk_out hold, tick <= 0.
- Load handshake:
  - load_ready = ~pending[load_ch] (combinational, no dependency on load_valid).
  - Transfer occurs when load_valid & load_ready: shadow[load_ch] <= load_div, pending[load_ch] <= 1.
  - load_ch >= N_CH: load_ready = 0, never accepted.
- Shadow apply: div <= shadow and pending <= 0, on the first edge at which pending was already 1 before that edge and any one of the following holds:
  - (a) the channel is at terminal count with en=1;
  - (b) en=0;
  - (c) sync=1.
- A load accepted on the same edge as a terminal count applies at the next boundary, not the current one.
- sync=1 (all channels, regardless of en): count <= 0, clk_out <= 0, tick <= 0, and pending shadows are applied. Channels restart in phase.
- Priority order: rst > sync > counting. A load accepted in the same cycle as sync stays pending.
- No arithmetic overflow: count never exceeds D_eff-1. Comparison is on WIDTH bits, unsigned.

Optional Feature:
- Macro: CLKDIV_DUTY_EN.
- Defined:
  - adds input `duty_hi` (N_CH*WIDTH, channel i at bits [i*WIDTH +: WIDTH]);
  - the channel runs a full period of 2*D_eff cycles, with clk_out high for min(duty_hi, 2*D_eff-1) cycles, then low;
  - tick pulses only on the rising edge of clk_out;
  - duty_hi = 0 holds clk_out low with no ticks.
- Undefined: port absent; fixed 50% toggle behaviour as above.

Test Plan (N_CH=2, WIDTH=8, DEFAULT_DIV=4 unless noted):
- Reset, en=2'b11 -> clk_out toggles on cycles 4,8,12…, period 8; tick high exactly on those cycles; both channels in phase.
- Load ch0 D=2 at cycle 1 -> pending[0]=1, load_ready low for ch0 and still high for ch1; new ratio applied at cycle 4 toggle; later toggles at 6,8,10; pending[0] clears at cycle 4.
- Load D=0 to ch1 -> after next boundary ch1 clk_out toggles every cycle, tick constantly 1.
- en[0]=0 for 5 cycles mid-period -> count/clk_out frozen, tick 0; resumes with remaining count; pending divisor applied on the first disabled cycle.
- ch0 D=3, ch1 D=5 running, pulse sync -> both clk_out=0, count=0 next edge; first toggles 3 and 5 cycles later.
- Assert rst while pending=1 mid-period -> next edge: all outputs 0, pending 0, div back to 4; a load_valid held during rst is not accepted.

Source files
------------

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: N_CH independent runtime-programmable clock dividers.
// Each channel toggles clk_out every D_eff enabled cycles and pulses tick on
// each toggle. New divisors go into a per-channel shadow register and are
// applied only at a period boundary, while disabled, or on sync, so no runt
// pulses are produced.
// Optional feature macro: CLKDIV_DUTY_EN adds a per-channel duty_hi input and
// switches each channel to a full-period counter with programmable high time.
module clock_divider_bank #(
    parameter int N_CH        = 4,
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 50000000,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef CLKDIV_DUTY_EN
    input  logic [N_CH*WIDTH-1:0] duty_hi,
`endif
    input  logic [N_CH-1:0]       en,
    input  logic                  sync,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [CH_W-1:0]       load_ch,
    input  logic [WIDTH-1:0]      load_div,
    output logic [N_CH-1:0]       pending,
    output logic [N_CH-1:0]       clk_out,
    output logic [N_CH-1:0]       tick
);

`ifdef CLKDIV_DUTY_EN
    // Counter spans the whole period (2*D_eff cycles), so it needs one extra bit.
    localparam int CNT_W = WIDTH + 1;
`else
    localparam int CNT_W = WIDTH;
`endif

    logic [WIDTH-1:0] div_q    [N_CH];
    logic [WIDTH-1:0] div_d    [N_CH];
    logic [WIDTH-1:0] shadow_q [N_CH];
    logic [WIDTH-1:0] shadow_d [N_CH];
    logic [CNT_W-1:0] count_q  [N_CH];
    logic [CNT_W-1:0] count_d  [N_CH];
    logic [N_CH-1:0]  pending_q, pending_d;
    logic [N_CH-1:0]  clk_out_q, clk_out_d;
    logic [N_CH-1:0]  tick_q, tick_d;

    logic [WIDTH-1:0] d_eff    [N_CH];
    logic [CNT_W-1:0] last_cnt [N_CH];
    logic [N_CH-1:0]  term;
    logic [N_CH-1:0]  accept;
`ifdef CLKDIV_DUTY_EN
    logic [CNT_W-1:0] hi_lim   [N_CH];
`endif

    // Effective divisor, terminal count value and terminal-count detect per channel.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            d_eff[i] = (div_q[i] == '0) ? WIDTH'(1) : div_q[i];
`ifdef CLKDIV_DUTY_EN
            last_cnt[i] = {d_eff[i], 1'b0} - CNT_W'(1);
            hi_lim[i]   = (CNT_W'(duty_hi[i*WIDTH +: WIDTH]) > last_cnt[i])
                          ? last_cnt[i] : CNT_W'(duty_hi[i*WIDTH +: WIDTH]);
`else
            last_cnt[i] = d_eff[i] - WIDTH'(1);
`endif
            // ">=" keeps the counter bounded when a smaller divisor lands
            // while the channel is paused part-way through a period.
            term[i] = (count_q[i] >= last_cnt[i]);
        end
    end

    // Load port: ready reflects the addressed channel's shadow being free;
    // out-of-range channel numbers match no channel and are never ready.
    always_comb begin
        load_ready = 1'b0;
        accept     = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (load_ch == CH_W'(i)) begin
                load_ready = ~pending_q[i];
                accept[i]  = load_valid & ~pending_q[i];
            end
        end
    end

    // Next-state: shadow apply, shadow load, then sync/count/hold per channel.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            div_d[i]     = div_q[i];
            shadow_d[i]  = shadow_q[i];
            pending_d[i] = pending_q[i];
            count_d[i]   = count_q[i];
            clk_out_d[i] = clk_out_q[i];
            tick_d[i]    = 1'b0;

            // Apply only a shadow that was already pending before this edge.
            if (pending_q[i] && (sync || !en[i] || term[i])) begin
                div_d[i]     = shadow_q[i];
                pending_d[i] = 1'b0;
            end
            // Accept is exclusive with apply: it needs pending_q low.
            if (accept[i]) begin
                shadow_d[i]  = load_div;
                pending_d[i] = 1'b1;
            end

            if (sync) begin
                count_d[i]   = '0;
                clk_out_d[i] = 1'b0;
            end else if (en[i]) begin
`ifdef CLKDIV_DUTY_EN
                count_d[i]   = term[i] ? '0 : count_q[i] + CNT_W'(1);
                clk_out_d[i] = (count_d[i] < hi_lim[i]);
                tick_d[i]    = clk_out_d[i] & ~clk_out_q[i];
`else
                if (term[i]) begin
                    count_d[i]   = '0;
                    clk_out_d[i] = ~clk_out_q[i];
                    tick_d[i]    = 1'b1;
                end else begin
                    count_d[i]   = count_q[i] + CNT_W'(1);
                end
`endif
            end
        end
    end

    // State registers with synchronous reset to the default divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                div_q[i]    <= WIDTH'(DEFAULT_DIV);
                shadow_q[i] <= '0;
                count_q[i]  <= '0;
            end
            pending_q <= '0;
            clk_out_q <= '0;
            tick_q    <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                div_q[i]    <= div_d[i];
                shadow_q[i] <= shadow_d[i];
                count_q[i]  <= count_d[i];
            end
            pending_q <= pending_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign pending = pending_q;
    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Testbench for clock_divider_bank (N_CH=2, WIDTH=8, DEFAULT_DIV=4).
module tb_clock_divider_bank;

    localparam int N_CH        = 2;
    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_CH-1:0]  en;
    logic             sync;
    logic             load_valid;
    logic             load_ready;
    logic [0:0]       load_ch;
    logic [WIDTH-1:0] load_div;
    logic [N_CH-1:0]  pending;
    logic [N_CH-1:0]  clk_out;
    logic [N_CH-1:0]  tick;

    always #5 clk = ~clk;

    clock_divider_bank #(
        .N_CH(N_CH), .WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_ch(load_ch), .load_div(load_div),
        .pending(pending), .clk_out(clk_out), .tick(tick)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: per channel, cycles elapsed in the current half-period.
    int m_div  [N_CH];
    int m_sh   [N_CH];
    int m_pend [N_CH];
    int m_el   [N_CH];
    int m_clk  [N_CH];
    int m_tick [N_CH];

    typedef struct packed {
        logic [1:0] en;
        logic       lv;
        logic [0:0] lch;
        logic [7:0] ldiv;
        logic       rdy;
        logic [1:0] clk_o;
        logic [1:0] tick_o;
        logic [1:0] pend_o;
    } vec_t;
    vec_t tbl [12];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_div[i] = DEFAULT_DIV; m_sh[i] = 0; m_pend[i] = 0;
            m_el[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
        end
    endfunction

    function automatic int pack2(input int a0, input int a1);
        return (a1 << 1) | a0;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void model_step();
        int ready;
        ready = (m_pend[int'(load_ch)] == 0) ? 1 : 0;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N_CH; i++) begin
            int  deff;
            bit  at_end;
            deff   = (m_div[i] == 0) ? 1 : m_div[i];
            at_end = (m_el[i] + 1 >= deff);
            if (m_pend[i] != 0 && (sync || !en[i] || at_end)) begin
                m_div[i]  = m_sh[i];
                m_pend[i] = 0;
            end else if (load_valid && ready == 1 && int'(load_ch) == i) begin
                m_sh[i]   = int'(load_div);
                m_pend[i] = 1;
            end
            if (sync) begin
                m_el[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
            end else if (en[i]) begin
                if (at_end) begin
                    m_el[i] = 0; m_clk[i] = 1 - m_clk[i]; m_tick[i] = 1;
                end else begin
                    m_el[i] = m_el[i] + 1; m_tick[i] = 0;
                end
            end else begin
                m_tick[i] = 0;
            end
        end
    endfunction

    // One checked clock cycle: ready before the edge, outputs after it.
    task automatic cycle();
        #1;
        check("load_ready", int'(load_ready), (m_pend[int'(load_ch)] == 0) ? 1 : 0);
        model_step();
        @(posedge clk);
        #1;
        check("clk_out", int'(clk_out), pack2(m_clk[0], m_clk[1]));
        check("tick",    int'(tick),    pack2(m_tick[0], m_tick[1]));
        check("pending", int'(pending), pack2(m_pend[0], m_pend[1]));
    endtask

    task automatic set_in(input logic [1:0] e, input logic s, input logic lv,
                          input logic [0:0] ch, input logic [7:0] d);
        en = e; sync = s; load_valid = lv; load_ch = ch; load_div = d;
    endtask

    // Cycle index (from 1) of the first tick on each channel, -1 if none.
    task automatic first_ticks(output int t0, output int t1);
        t0 = -1; t1 = -1;
        for (int c = 1; c <= 12; c++) begin
            cycle();
            if (t0 < 0 && tick[0]) t0 = c;
            if (t1 < 0 && tick[1]) t1 = c;
        end
    endtask

    initial begin
        int t0, t1;
        logic frozen;

        //             en     lv    lch   ldiv  rdy   clk    tick   pend
        tbl[0]  = {2'b11, 1'b1, 1'b0, 8'd2, 1'b1, 2'b00, 2'b00, 2'b01};
        tbl[1]  = {2'b11, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00, 2'b00, 2'b01};
        tbl[2]  = {2'b11, 1'b0, 1'b1, 8'd0, 1'b1, 2'b00, 2'b00, 2'b01};
        tbl[3]  = {2'b11, 1'b0, 1'b0, 8'd0, 1'b0, 2'b11, 2'b11, 2'b00};
        tbl[4]  = {2'b11, 1'b0, 1'b0, 8'd0, 1'b1, 2'b11, 2'b00, 2'b00};
        tbl[5]  = {2'b11, 1'b0, 1'b0, 8'd0, 1'b1, 2'b10, 2'b01, 2'b00};
        tbl[6]  = {2'b11, 1'b0, 1'b0, 8'd0, 1'b1, 2'b10, 2'b00, 2'b00};
        tbl[7]  = {2'b11, 1'b0, 1'b0, 8'd0, 1'b1, 2'b01, 2'b11, 2'b00};
        tbl[8]  = {2'b11, 1'b0, 1'b0, 8'd0, 1'b1, 2'b01, 2'b00, 2'b00};
        tbl[9]  = {2'b11, 1'b0, 1'b0, 8'd0, 1'b1, 2'b00, 2'b01, 2'b00};
        tbl[10] = {2'b11, 1'b0, 1'b0, 8'd0, 1'b1, 2'b00, 2'b00, 2'b00};
        tbl[11] = {2'b11, 1'b0, 1'b0, 8'd0, 1'b1, 2'b11, 2'b11, 2'b00};

        // Initial reset edge, then check the reset state.
        rst = 1'b1;
        set_in(2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
        @(posedge clk);
        #1;
        model_reset();
        check("reset_clk_out", int'(clk_out), 0);
        check("reset_tick",    int'(tick),    0);
        check("reset_pending", int'(pending), 0);
        rst = 1'b0;

        // Table: free run at default divisor plus a ch0 reload to D=2.
        for (int k = 0; k < 12; k++) begin
            set_in(tbl[k].en, 1'b0, tbl[k].lv, tbl[k].lch, tbl[k].ldiv);
            #1;
            check($sformatf("tbl%0d_ready", k + 1), int'(load_ready), int'(tbl[k].rdy));
            cycle();
            check($sformatf("tbl%0d_clk", k + 1),  int'(clk_out), int'(tbl[k].clk_o));
            check($sformatf("tbl%0d_tick", k + 1), int'(tick),    int'(tbl[k].tick_o));
            check($sformatf("tbl%0d_pend", k + 1), int'(pending), int'(tbl[k].pend_o));
        end

        // D=0 on ch1: after its next boundary it toggles and ticks every cycle.
        set_in(2'b11, 1'b0, 1'b1, 1'b1, 8'd0);
        cycle();
        set_in(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int c = 0; c < 5; c++) cycle();
        for (int c = 0; c < 4; c++) begin
            cycle();
            check("d0_tick_ch1", int'(tick[1]), 1);
        end
        set_in(2'b11, 1'b0, 1'b1, 1'b1, 8'd4);
        cycle();
        set_in(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
        cycle();

        // ch0 paused for 5 cycles with a pending divisor: frozen, applied at once.
        set_in(2'b11, 1'b0, 1'b1, 1'b0, 8'd6);
        cycle();
        set_in(2'b10, 1'b0, 1'b0, 1'b0, 8'd0);
        frozen = clk_out[0];
        for (int c = 0; c < 5; c++) begin
            cycle();
            check("pause_clk_ch0",  int'(clk_out[0]), int'(frozen));
            check("pause_tick_ch0", int'(tick[0]), 0);
            check("pause_pend_ch0", int'(pending[0]), 0);
        end
        set_in(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int c = 0; c < 8; c++) cycle();

        // Sync with ch0 D=3, ch1 D=5 shadowed: phase-aligned restart.
        set_in(2'b11, 1'b0, 1'b1, 1'b0, 8'd3);
        cycle();
        set_in(2'b11, 1'b0, 1'b1, 1'b1, 8'd5);
        cycle();
        set_in(2'b11, 1'b1, 1'b0, 1'b0, 8'd0);
        cycle();
        check("sync_clk_out", int'(clk_out), 0);
        check("sync_pending", int'(pending), 0);
        set_in(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
        first_ticks(t0, t1);
        check("sync_first_tick_ch0", t0, 3);
        check("sync_first_tick_ch1", t1, 5);

        // Reset while a load is pending; a load held during reset is ignored.
        set_in(2'b11, 1'b0, 1'b1, 1'b0, 8'd7);
        cycle();
        check("pre_rst_pend_ch0", int'(pending[0]), 1);
        rst = 1'b1;
        set_in(2'b11, 1'b0, 1'b1, 1'b1, 8'd9);
        cycle();
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_tick",    int'(tick),    0);
        check("rst_pending", int'(pending), 0);
        rst = 1'b0;
        set_in(2'b11, 1'b0, 1'b0, 1'b0, 8'd0);
        first_ticks(t0, t1);
        check("rst_first_tick_ch0", t0, 4);
        check("rst_first_tick_ch1", t1, 4);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            set_in(2'($urandom_range(0, 3)), ($urandom_range(0, 29) == 0),
                   ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 6)));
            if ($urandom_range(0, 3) != 0) en = 2'b11;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
